// File: rtl/add_pipe_vr.sv
// Parametrised valid/ready adder pipeline: p1 holds operands, p2 the sum, p3..pSTAGES delay copies.
// Empty stages always load, so bubbles collapse under back-pressure; in_ready is combinational.
module add_pipe_vr #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CW     = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic [CW-1:0]    count
);

    logic [STAGES:1] v;
    logic [STAGES:1] adv;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [WIDTH:0]   d [2:STAGES];
    logic [WIDTH:0]   sum_w;
    logic             acc_in;
    logic             acc_out;

    assign sum_w = {1'b0, xr} + {1'b0, yr};

    // A stage advances if the consumer takes data or any stage at or below it is empty.
    always_comb begin
        logic a;
        a   = out_ready;
        adv = '0;
        for (int k = STAGES; k >= 1; k--) begin
            a      = a || !v[k];
            adv[k] = a;
        end
    end

    assign in_ready  = adv[1] && !rst;
    assign acc_in    = in_valid && in_ready;
    assign acc_out   = v[STAGES] && out_ready;
    assign out_valid = v[STAGES];
    assign out       = d[STAGES][WIDTH-1:0];
    assign carry     = d[STAGES][WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v     <= '0;
            xr    <= '0;
            yr    <= '0;
            count <= '0;
            for (int k = 2; k <= STAGES; k++) begin
                d[k] <= '0;
            end
        end else begin
            if (adv[1]) begin
                v[1] <= in_valid;
                xr   <= x;
                yr   <= y;
            end
            if (adv[2]) begin
                v[2] <= v[1];
                d[2] <= sum_w;
            end
            for (int k = 3; k <= STAGES; k++) begin
                if (adv[k]) begin
                    v[k] <= v[k-1];
                    d[k] <= d[k-1];
                end
            end
            if (acc_in && !acc_out) begin
                count <= count + CW'(1);
            end else if (acc_out && !acc_in) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
